demo_6: RTL and testbench

- Registered N-bit binary adder built on carry-lookahead logic: f = a + b + c0, with carry-out c4.
- Default width is 4 bits: the 4-bit carry-lookahead adder used in the digital-electronics lab datapath.
- Sum and carry are computed combinationally by lookahead groups, then captured in an output register on the clock edge.

---
 rtl/demo_6_pkg.sv | 12 +
 rtl/demo_6_cla4_group.sv | 38 +++
 rtl/demo_6.sv | 60 ++++++
 tb/tb_demo_6.sv | 118 +++++++++++
 4 files changed

// File: rtl/demo_6_pkg.sv
// Shared definitions for the demo_6 carry-lookahead adder.
//   GROUP_W    : width of one lookahead group (4 bits)
//   num_groups : number of 4-bit groups needed for a given operand width
package demo_6_pkg;

  localparam int GROUP_W = 4;

  function automatic int num_groups(input int width);
    return width / GROUP_W;
  endfunction

endpackage

// File: rtl/demo_6_cla4_group.sv
// One 4-bit carry-lookahead group, purely combinational.
// Ports:
//   a, b : 4-bit operand slices
//   cin  : carry into the group
//   s    : 4-bit sum slice
//   G, P : group generate / group propagate for the next lookahead level
module cla4_group
  import demo_6_pkg::*;
(
  input  logic [GROUP_W-1:0] a,
  input  logic [GROUP_W-1:0] b,
  input  logic               cin,
  output logic [GROUP_W-1:0] s,
  output logic               G,
  output logic               P
);

  logic [GROUP_W-1:0] gen;
  logic [GROUP_W-1:0] prop;
  logic [GROUP_W-1:0] c;

  assign gen  = a & b;
  assign prop = a ^ b;

  // Carries fully expanded from cin so no carry ripples through the group.
  assign c[0] = cin;
  assign c[1] = gen[0] | (prop[0] & cin);
  assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
  assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
              | (prop[2] & prop[1] & prop[0] & cin);

  assign s = prop ^ c;

  assign G = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
           | (prop[3] & prop[2] & prop[1] & gen[0]);
  assign P = &prop;

endmodule

// File: rtl/demo_6.sv
// Registered WIDTH-bit carry-lookahead adder: {c4, f} = a + b + c0, one clock
// of latency, a new operation accepted every cycle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset, clears f and c4
//   a, b : unsigned operands
//   c0   : carry-in
//   c4   : registered carry-out of the MSB
//   f    : registered sum (lower WIDTH bits)
module demo_6
  import demo_6_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic             c4,
  output logic [WIDTH-1:0] f
);

  localparam int NG = num_groups(WIDTH);

  if ((WIDTH < GROUP_W) || ((WIDTH % GROUP_W) != 0)) begin : g_width_check
    $error("demo_6: WIDTH must be a positive multiple of 4");
  end

  logic [NG:0]      grp_c;
  logic [NG-1:0]    grp_g;
  logic [NG-1:0]    grp_p;
  logic [WIDTH-1:0] sum;

  assign grp_c[0] = c0;

  for (genvar k = 0; k < NG; k++) begin : g_grp
    cla4_group u_grp (
      .a   (a[k*GROUP_W +: GROUP_W]),
      .b   (b[k*GROUP_W +: GROUP_W]),
      .cin (grp_c[k]),
      .s   (sum[k*GROUP_W +: GROUP_W]),
      .G   (grp_g[k]),
      .P   (grp_p[k])
    );
    // Second-level lookahead: carry into the next group from this group's G/P.
    assign grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f  <= '0;
      c4 <= 1'b0;
    end else begin
      f  <= sum;
      c4 <= grp_c[NG];
    end
  end

endmodule

// File: tb/tb_demo_6.sv
module tb_demo_6;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a4,  b4,  f4;
  logic [7:0]  a8,  b8,  f8;
  logic [15:0] a16, b16, f16;
  logic        c04, c08, c016;
  logic        c4_4, c4_8, c4_16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  demo_6 #(.WIDTH(4)) u_d4 (
    .clk(clk), .rst(rst), .a(a4), .b(b4), .c0(c04), .c4(c4_4), .f(f4)
  );
  demo_6 #(.WIDTH(8)) u_d8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c0(c08), .c4(c4_8), .f(f8)
  );
  demo_6 #(.WIDTH(16)) u_d16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .c0(c016), .c4(c4_16), .f(f16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one vector to the 4-bit adder, clock it, check {c4, f}.
  task automatic step4(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                       input logic tc, input logic trst, input logic [4:0] exp);
    a4  = ta;
    b4  = tb;
    c04 = tc;
    rst = trst;
    @(posedge clk);
    #1;
    chk(tag, {27'd0, c4_4, f4}, {27'd0, exp});
  endtask

  logic [4:0]  e4;
  logic [8:0]  e8;
  logic [16:0] e16;

  initial begin
    rst = 1'b1;
    a4 = 4'h0; b4 = 4'h0; c04 = 1'b0;
    a8 = 8'h0; b8 = 8'h0; c08 = 1'b0;
    a16 = 16'h0; b16 = 16'h0; c016 = 1'b0;

    // Reset dominates all-ones inputs.
    step4("rst_1", 4'hF, 4'hF, 1'b1, 1'b1, 5'h00);
    step4("rst_2", 4'hF, 4'hF, 1'b1, 1'b1, 5'h00);

    step4("zero",      4'h0, 4'h0, 1'b0, 1'b0, 5'h00);
    step4("0+1+1",     4'h0, 4'h1, 1'b1, 1'b0, 5'h02);
    step4("1+1+1",     4'h1, 4'h1, 1'b1, 1'b0, 5'h03);
    step4("F+1+1",     4'hF, 4'h1, 1'b1, 1'b0, 5'h11);
    step4("F+0+1",     4'hF, 4'h0, 1'b1, 1'b0, 5'h10);
    step4("b2b_7+8",   4'h7, 4'h8, 1'b0, 1'b0, 5'h0F);
    step4("b2b_F+F+1", 4'hF, 4'hF, 1'b1, 1'b0, 5'h1F);

    // Inputs changing between edges must not disturb the registered outputs.
    a4 = 4'h0; b4 = 4'h0; c04 = 1'b0;
    #3;
    chk("hold", {27'd0, c4_4, f4}, 32'h1F);

    step4("b2b2_7+8",  4'h7, 4'h8, 1'b0, 1'b0, 5'h0F);
    step4("rst_mid",   4'hF, 4'hF, 1'b1, 1'b1, 5'h00);
    step4("after_rst", 4'hF, 4'hF, 1'b1, 1'b0, 5'h1F);

    // Wide instances: carries crossing group boundaries.
    a8 = 8'hFF; b8 = 8'h00; c08 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'h0000; c016 = 1'b1;
    @(posedge clk); #1;
    chk("w8_allones",  {23'd0, c4_8, f8},   32'h100);
    chk("w16_allones", {15'd0, c4_16, f16}, 32'h10000);

    a8 = 8'h0F; b8 = 8'h01; c08 = 1'b0;
    a16 = 16'h8000; b16 = 16'h8000; c016 = 1'b0;
    @(posedge clk); #1;
    chk("w8_grp_carry", {23'd0, c4_8, f8},   32'h010);
    chk("w16_msb_ovf",  {15'd0, c4_16, f16}, 32'h10000);

    a16 = 16'h1234; b16 = 16'h4321; c016 = 1'b1;
    @(posedge clk); #1;
    chk("w16_mixed", {15'd0, c4_16, f16}, 32'h05556);

    // Exhaustive 4-bit sweep alongside random 8/16-bit operands.
    for (int i = 0; i < 512; i++) begin
      a4   = i[3:0];
      b4   = i[7:4];
      c04  = i[8];
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      c08  = 1'($urandom_range(0, 1));
      a16  = 16'($urandom);
      b16  = 16'($urandom);
      c016 = 1'($urandom_range(0, 1));
      e4  = 5'(a4)   + 5'(b4)   + 5'(c04);
      e8  = 9'(a8)   + 9'(b8)   + 9'(c08);
      e16 = 17'(a16) + 17'(b16) + 17'(c016);
      @(posedge clk); #1;
      chk("sweep4",  {27'd0, c4_4, f4},   {27'd0, e4});
      chk("rand8",   {23'd0, c4_8, f8},   {23'd0, e8});
      chk("rand16",  {15'd0, c4_16, f16}, {15'd0, e16});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
